// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential-multiplier scheduler.
// Contents: FSM state encoding, default operand width and multiplier
// latency, and the latency-counter width derived from that latency.
package seq_mult_pkg;

   localparam int W_DEF        = 4;
   localparam int MULT_LAT_DEF = 5;

   // Counter must hold MULT_LAT-1; one spare bit keeps MULT_LAT=1 legal.
   localparam int CNT_W = $clog2(MULT_LAT_DEF) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/seq_mult_sched_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter, purely combinational.
// Ports:
//   req[1:0]  request lines
//   ptr       preferred requester when both request (0 or 1)
//   gnt[1:0]  one-hot grant, zero when nobody requests
// The pointer register lives in the parent so it can advance only on an
// actual accept.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   assign gnt[0] = req[0] & (~req[1] | ~ptr);
   assign gnt[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/seq_mult_sched.sv
// seq_mult_sched: shares one fixed-latency sequential multiplier between
// two requesters. Round-robin arbitration, operand latch, start pulse,
// latency count, product capture and valid/ready response with owner ID.
// Ports:
//   clk, clr                  clock and asynchronous active-high reset
//   req_valid/req_ready[1:0]  per-requester request handshake
//   req_a0/req_b0, req_a1/req_b1  requester operands (W bits)
//   rsp_valid/rsp_ready       response handshake
//   rsp_id, rsp_p             owner of the response and 2W-bit product
//   mult_start, mult_a, mult_b, mult_p  multiplier interface
//   busy                      high whenever the FSM is not in IDLE
// Build option: define ZERO_BYPASS_EN to answer requests with a zero
// operand directly (product 0, no multiplier start).
//
// state | meaning
// IDLE  | arbitrate, accept one request, latch operands and owner
// ISSUE | pulse mult_start, load latency counter
// WAIT  | count down multiplier latency, capture product at zero
// DONE  | hold response until rsp_ready
module seq_mult_sched
   import seq_mult_pkg::*;
#(
   parameter int W        = W_DEF,
   parameter int MULT_LAT = MULT_LAT_DEF
) (
   input  logic           clk,
   input  logic           clr,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [W-1:0]   req_a0,
   input  logic [W-1:0]   req_b0,
   input  logic [W-1:0]   req_a1,
   input  logic [W-1:0]   req_b1,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [2*W-1:0] rsp_p,
   output logic           mult_start,
   output logic [W-1:0]   mult_a,
   output logic [W-1:0]   mult_b,
   input  logic [2*W-1:0] mult_p,
   output logic           busy
);

   localparam int CW = $clog2(MULT_LAT) + 1;

   state_t          state;
   logic            ptr;
   logic [CW-1:0]   cnt;
   logic [1:0]      gnt;
   logic            accept;
   logic            acc_id;
   logic [W-1:0]    acc_a;
   logic [W-1:0]    acc_b;

   rr_arb2 u_arb (
      .req (req_valid),
      .ptr (ptr),
      .gnt (gnt)
   );

   assign req_ready  = (state == IDLE) ? gnt : 2'b00;
   assign accept     = |(req_valid & req_ready);
   assign acc_id     = req_ready[1];
   assign acc_a      = acc_id ? req_a1 : req_a0;
   assign acc_b      = acc_id ? req_b1 : req_b0;

   assign mult_start = (state == ISSUE);
   assign rsp_valid  = (state == DONE);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= IDLE;
         ptr    <= 1'b0;
         cnt    <= '0;
         rsp_id <= 1'b0;
         rsp_p  <= '0;
         mult_a <= '0;
         mult_b <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mult_a <= acc_a;
                  mult_b <= acc_b;
                  rsp_id <= acc_id;
                  ptr    <= ~acc_id;
`ifdef ZERO_BYPASS_EN
                  if ((acc_a == '0) || (acc_b == '0)) begin
                     rsp_p <= '0;
                     state <= DONE;
                  end else begin
                     state <= ISSUE;
                  end
`else
                  state <= ISSUE;
`endif
               end
            end
            ISSUE: begin
               cnt   <= CW'(MULT_LAT - 1);
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  rsp_p <= mult_p;
                  state <= DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
